multicycle_control: RTL and testbench

Main control unit for the multicycle RV32I subset core (addi, lw, sw, add, sub, and, or, beq). It sits directly upstream of the datapath: it consumes the instruction register fields and the ALU zero flag, and it drives every mux select, write enable and ALU control code the datapath registers and muxes need. It is a Moore FSM. Illegal encodings park it in a halt state until reset.

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = controller (drives enables/selects), slave = datapath (drives IR fields and zero).
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCSource;
    logic [3:0] alu_control;
    logic       retire;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, alu_control, retire, halted, state
    );
    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, alu_control, retire, halted, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I subset core (addi, lw, sw, add, sub, and, or, beq).
// Illegal encodings park the FSM in HALT until reset.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        EXEC_I    = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t     state_q, state_d;
    logic       pc_write_uncond, branch;
    logic       mem_read, mem_write, ir_write, reg_write, retire_s, halted_s;
    logic       iord, mem_to_reg, alu_src_a, pc_source;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       r_legal;
    logic [3:0] r_alu;

    // R-type funct decode: {funct7_5, funct3}
    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case ({bus.funct7_5, bus.funct3})
            4'b0_000: r_alu = ALU_ADD;
            4'b1_000: r_alu = ALU_SUB;
            4'b0_111: r_alu = ALU_AND;
            4'b0_110: r_alu = ALU_OR;
            default:  r_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        pc_write_uncond = 1'b0;
        branch          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        retire_s        = 1'b0;
        halted_s        = 1'b0;
        iord            = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_source       = 1'b0;
        alu_ctl         = ALU_ADD;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                // PC takes old PC+4 while ALUOut captures old PC+imm as branch target
                pc_write_uncond = 1'b1;
                pc_source       = 1'b1;
                alu_src_b       = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = (bus.funct3 == 3'b010) ? MEM_ADDR : HALT;
                    OP_R:              state_d = r_legal ? EXEC_R : HALT;
                    OP_IMM:            state_d = (bus.funct3 == 3'b000) ? EXEC_I : HALT;
                    OP_BR:             state_d = (bus.funct3 == 3'b000) ? BRANCH : HALT;
                    default:           state_d = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_s   = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire_s  = 1'b1;
                state_d   = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = r_alu;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                retire_s  = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                branch    = 1'b1;
                pc_source = 1'b1;
                retire_s  = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                halted_s = 1'b1;
                state_d  = HALT;
            end
            default: state_d = HALT;
        endcase
    end

    // Enables are masked during reset so a mid-instruction reset commits nothing
    assign bus.PCWrite     = !reset && (pc_write_uncond || (branch && bus.zero));
    assign bus.MemRead     = !reset && mem_read;
    assign bus.MemWrite    = !reset && mem_write;
    assign bus.IRWrite     = !reset && ir_write;
    assign bus.RegWrite    = !reset && reg_write;
    assign bus.retire      = !reset && retire_s;
    assign bus.halted      = !reset && halted_s;
    assign bus.IorD        = iord;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.alu_control = alu_ctl;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench: small multicycle datapath driven by the controller, checked against an ISA-level interpreter.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_READ = 4'd3;
    localparam logic [3:0] S_EXEC_R = 4'd6, S_HALT = 4'd10;

    int total = 0;
    int bad = 0;

    logic [7:0]  img[256];
    logic [7:0]  mem[256];
    logic [31:0] rf_init[32];
    logic [31:0] rf[32];
    logic [31:0] pc, ir, a_r, b_r, aluout, mdr, imm, src_a, src_b, alu_y, rd_word;
    logic [7:0]  maddr;

    assign bus.opcode   = ir[6:0];
    assign bus.funct3   = ir[14:12];
    assign bus.funct7_5 = ir[30];
    assign bus.zero     = (alu_y == 32'd0);

    always_comb begin
        maddr   = bus.IorD ? aluout[7:0] : pc[7:0];
        rd_word = {mem[maddr + 8'd3], mem[maddr + 8'd2], mem[maddr + 8'd1], mem[maddr]};
        imm     = {{20{ir[31]}}, ir[31:20]};
        if (ir[6:0] == 7'b0100011) imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        if (ir[6:0] == 7'b1100011) imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        src_a = bus.ALUSrcA ? a_r : pc;
        src_b = b_r;
        if (bus.ALUSrcB == 2'b01) src_b = 32'd4;
        if (bus.ALUSrcB == 2'b10) src_b = imm;
        alu_y = src_a + src_b;
        if (bus.alu_control == 4'b0000) alu_y = src_a & src_b;
        if (bus.alu_control == 4'b0001) alu_y = src_a | src_b;
        if (bus.alu_control == 4'b0110) alu_y = src_a - src_b;
    end

    always @(posedge clk) begin
        if (reset) begin
            pc  <= 32'd0;
            ir  <= 32'd0;
            mem <= img;
            rf  <= rf_init;
        end else begin
            if (bus.IRWrite) ir <= rd_word;
            if (bus.PCWrite) pc <= bus.PCSource ? aluout : alu_y;
            if (bus.RegWrite && ir[11:7] != 5'd0) rf[ir[11:7]] <= bus.MemtoReg ? mdr : aluout;
            if (bus.MemWrite) begin
                mem[maddr]         <= b_r[7:0];
                mem[maddr + 8'd1]  <= b_r[15:8];
                mem[maddr + 8'd2]  <= b_r[23:16];
                mem[maddr + 8'd3]  <= b_r[31:24];
            end
        end
        a_r    <= rf[ir[19:15]];
        b_r    <= rf[ir[24:20]];
        aluout <= alu_y;
        mdr    <= rd_word;
    end

    // ---------------- encoders and image helpers ----------------
    function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1, input int im);
        logic [31:0] o, d, f, s, m;
        o = op; d = rd; f = f3; s = rs1; m = im;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] g, t, s, f, d;
        g = f7; t = rs2; s = rs1; f = f3; d = rd;
        return {1'b0, g[0], 5'b0, t[4:0], s[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int im);
        logic [31:0] t, s, m;
        t = rs2; s = rs1; m = im;
        return {m[11:5], t[4:0], s[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int im);
        logic [31:0] s, t, m;
        s = rs1; t = rs2; m = im;
        return {m[12], m[10:5], t[4:0], s[4:0], 3'b000, m[4:1], m[11], 7'b1100011};
    endfunction

    task automatic put_word(input int addr, input logic [31:0] w);
        logic [31:0] a;
        a = addr;
        img[a[7:0]]        = w[7:0];
        img[a[7:0] + 8'd1] = w[15:8];
        img[a[7:0] + 8'd2] = w[23:16];
        img[a[7:0] + 8'd3] = w[31:24];
    endtask

    task automatic clear_image();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        for (int i = 0; i < 128; i += 4) put_word(i, 32'h0000007F);
        for (int i = 0; i < 32; i++) rf_init[i] = 32'd0;
    endtask

    // ---------------- ISA-level reference ----------------
    logic [31:0] m_rf[32];
    logic [7:0]  m_mem[256];
    int          exp_ret[$];
    int          exp_halt;

    task automatic model_run();
        logic [31:0] p, ins, a, b, ii, is, ib, w;
        logic [7:0]  ea;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, wr;
        int          cyc;
        m_rf = rf_init; m_mem = img; p = 0; cyc = 0; exp_ret.delete(); exp_halt = -1;
        for (int n = 0; n < 64; n++) begin
            ins = {m_mem[p[7:0] + 8'd3], m_mem[p[7:0] + 8'd2], m_mem[p[7:0] + 8'd1], m_mem[p[7:0]]};
            op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
            a = m_rf[ins[19:15]]; b = m_rf[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            wr = 1'b0; w = 32'd0;
            if (op == 7'h13 && f3 == 3'd0) begin
                w = a + ii; wr = 1'b1; cyc += 4; p += 4;
            end else if (op == 7'h03 && f3 == 3'd2) begin
                ea = a[7:0] + ii[7:0];
                w = {m_mem[ea + 8'd3], m_mem[ea + 8'd2], m_mem[ea + 8'd1], m_mem[ea]};
                wr = 1'b1; cyc += 5; p += 4;
            end else if (op == 7'h23 && f3 == 3'd2) begin
                ea = a[7:0] + is[7:0];
                m_mem[ea] = b[7:0]; m_mem[ea + 8'd1] = b[15:8];
                m_mem[ea + 8'd2] = b[23:16]; m_mem[ea + 8'd3] = b[31:24];
                cyc += 4; p += 4;
            end else if (op == 7'h33 && !f7 && f3 == 3'd0) begin w = a + b; wr = 1'b1; cyc += 4; p += 4;
            end else if (op == 7'h33 &&  f7 && f3 == 3'd0) begin w = a - b; wr = 1'b1; cyc += 4; p += 4;
            end else if (op == 7'h33 && !f7 && f3 == 3'd7) begin w = a & b; wr = 1'b1; cyc += 4; p += 4;
            end else if (op == 7'h33 && !f7 && f3 == 3'd6) begin w = a | b; wr = 1'b1; cyc += 4; p += 4;
            end else if (op == 7'h63 && f3 == 3'd0) begin
                cyc += 3; p = (a == b) ? p + ib : p + 4;
            end else begin
                exp_halt = cyc + 3;
                break;
            end
            if (wr && ins[11:7] != 5'd0) m_rf[ins[11:7]] = w;
            exp_ret.push_back(cyc);
        end
    endtask

    // ---------------- run harness (records observations, cycle 1 = first FETCH) ----------------
    int          ret_q[$];
    logic [31:0] fpc_q[$];
    logic [3:0]  st_q[$];
    int          halt_cyc, mw_cnt, mw_bad, rw_cnt;
    logic [3:0]  ex_alu;

    task automatic run_prog(input int budget);
        ret_q.delete(); fpc_q.delete(); st_q.delete();
        halt_cyc = -1; mw_cnt = 0; mw_bad = 0; rw_cnt = 0; ex_alu = 4'hF;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            #1;
            st_q.push_back(bus.state);
            if (bus.retire) ret_q.push_back(c);
            if (bus.state == S_FETCH) fpc_q.push_back(pc);
            if (bus.MemWrite) begin mw_cnt++; if (!bus.IorD) mw_bad++; end
            if (bus.RegWrite) rw_cnt++;
            if (bus.state == S_EXEC_R) ex_alu = bus.alu_control;
            if (bus.halted) begin halt_cyc = c; break; end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] en;
        reset = 1'b1;
        #1;
        en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.retire, bus.halted};
        total++; if (en !== 7'b0) begin bad++; $display("FAIL reset_enables: got %b want 0000000", en); end
        @(negedge clk);
        total++; if (bus.state !== S_FETCH) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.retire, bus.halted};
        total++; if (en !== 7'b0) begin bad++; $display("FAIL reset_fetch_masked: got %b want 0000000", en); end
    endtask

    task automatic test_standard_program();
        int exp_r[5];
        exp_r = '{4, 9, 13, 17, 20};
        clear_image();
        put_word(0,  enc_i(19, 3, 0, 0, 20));
        put_word(4,  enc_i(3, 8, 2, 3, 120));
        put_word(8,  enc_r(0, 3, 8, 0, 10));
        put_word(12, enc_r(1, 8, 10, 0, 11));
        put_word(16, enc_b(3, 11, 4));
        put_word(20, enc_r(0, 11, 3, 7, 13));
        put_word(24, enc_r(0, 3, 8, 6, 14));
        put_word(140, 32'd82);
        run_prog(100);
        total++; if (halt_cyc !== 31) begin bad++; $display("FAIL std_halt_cycle: got %0d want 31", halt_cyc); end
        total++; if (rf[3]  !== 32'd20)  begin bad++; $display("FAIL std_x3: got %0d want 20", rf[3]); end
        total++; if (rf[8]  !== 32'd82)  begin bad++; $display("FAIL std_x8: got %0d want 82", rf[8]); end
        total++; if (rf[10] !== 32'd102) begin bad++; $display("FAIL std_x10: got %0d want 102", rf[10]); end
        total++; if (rf[11] !== 32'd20)  begin bad++; $display("FAIL std_x11: got %0d want 20", rf[11]); end
        total++; if (rf[13] !== 32'd20)  begin bad++; $display("FAIL std_x13: got %0d want 20", rf[13]); end
        total++; if (rf[14] !== 32'd86)  begin bad++; $display("FAIL std_x14: got %0d want 86", rf[14]); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ret_q.size() <= i || ret_q[i] !== exp_r[i]) begin
                bad++; $display("FAIL std_retire_%0d: got %0d want %0d", i, (ret_q.size() > i) ? ret_q[i] : -1, exp_r[i]);
            end
        end
        total++; if (fpc_q.size() < 6 || fpc_q[5] !== 32'd20) begin
            bad++; $display("FAIL beq_taken_pc: got %0d want 20", (fpc_q.size() > 5) ? fpc_q[5] : 32'hFFFFFFFF);
        end
    endtask

    task automatic test_branch(input bit taken);
        logic [31:0] want;
        clear_image();
        put_word(0,  enc_i(19, 3, 0, 0, 20));
        put_word(4,  enc_i(19, 4, 0, 0, 7));
        put_word(8,  enc_i(19, 0, 0, 0, 0));
        put_word(12, enc_i(19, 0, 0, 0, 0));
        put_word(16, enc_b(3, taken ? 3 : 4, 8));
        put_word(20, enc_i(19, 5, 0, 0, 1));
        put_word(24, enc_i(19, 6, 0, 0, 1));
        run_prog(100);
        want = taken ? 32'd24 : 32'd20;
        total++; if (fpc_q.size() < 6 || fpc_q[5] !== want) begin
            bad++; $display("FAIL beq_%0d_pc: got %0d want %0d", taken, (fpc_q.size() > 5) ? fpc_q[5] : 32'hFFFFFFFF, want);
        end
        total++; if (rf[5] !== (taken ? 32'd0 : 32'd1)) begin
            bad++; $display("FAIL beq_%0d_skip: got x5=%0d want %0d", taken, rf[5], taken ? 0 : 1);
        end
    endtask

    task automatic test_sw();
        clear_image();
        rf_init[3] = 32'd20;
        rf_init[8] = 32'hDEADBEEF;
        put_word(0, enc_s(8, 3, 0));
        run_prog(50);
        total++; if (halt_cyc !== 7) begin bad++; $display("FAIL sw_latency: got halt at %0d want 7", halt_cyc); end
        total++; if (mw_cnt !== 1 || mw_bad !== 0) begin
            bad++; $display("FAIL sw_memwrite: got %0d cycles (%0d with IorD=0) want 1 (0)", mw_cnt, mw_bad);
        end
        total++; if ({mem[23], mem[22], mem[21], mem[20]} !== 32'hDEADBEEF) begin
            bad++; $display("FAIL sw_bytes: got %h %h %h %h want ef be ad de", mem[20], mem[21], mem[22], mem[23]);
        end
    endtask

    task automatic test_illegal();
        int en_bad;
        clear_image();
        run_prog(20);
        total++; if (halt_cyc !== 3 || st_q.size() < 3 || st_q[1] !== S_DECODE || st_q[2] !== S_HALT) begin
            bad++; $display("FAIL illegal_path: got halt at %0d want DECODE->HALT at 3", halt_cyc);
        end
        en_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (bus.PCWrite || bus.IRWrite || bus.RegWrite || bus.MemWrite || bus.MemRead || bus.retire ||
                !bus.halted || bus.state !== S_HALT) en_bad++;
        end
        total++; if (en_bad !== 0) begin bad++; $display("FAIL halt_quiet: got %0d bad cycles want 0", en_bad); end
        reset = 1'b1;
        #1;
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_reset_mask: got halted=%b want 0", bus.halted); end
        @(negedge clk); #1;
        total++; if (bus.state !== S_FETCH) begin bad++; $display("FAIL halt_reset_state: got %0d want 0", bus.state); end
    endtask

    task automatic test_reset_mid();
        bit found, saw_rw;
        clear_image();
        put_word(0, enc_i(3, 8, 2, 0, 140));
        put_word(140, 32'd82);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        found = 0; saw_rw = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.RegWrite) saw_rw = 1;
            if (bus.state == S_MEM_READ) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL midreset_reach: got no MEM_READ want MEM_READ within 20 cycles"); end
        reset = 1'b1;
        #1;
        if (bus.RegWrite || bus.MemWrite || bus.PCWrite || bus.IRWrite || bus.MemRead) saw_rw = 1;
        @(negedge clk); #1;
        if (bus.RegWrite) saw_rw = 1;
        total++; if (bus.state !== S_FETCH) begin bad++; $display("FAIL midreset_state: got %0d want 0", bus.state); end
        total++; if (saw_rw || rf[8] !== 32'd0) begin
            bad++; $display("FAIL midreset_nowrite: got enable=%0d x8=%0d want 0 0", saw_rw, rf[8]);
        end
    endtask

    task automatic test_rtype_funct();
        clear_image();
        put_word(0, enc_r(1, 2, 1, 7, 3));
        run_prog(20);
        total++; if (halt_cyc !== 3) begin bad++; $display("FAIL r_f7_and_halt: got halt at %0d want 3", halt_cyc); end
        clear_image();
        rf_init[1] = 32'd50;
        rf_init[2] = 32'd8;
        put_word(0, enc_r(1, 2, 1, 0, 3));
        run_prog(30);
        total++; if (ex_alu !== 4'b0110) begin bad++; $display("FAIL r_sub_code: got %b want 0110", ex_alu); end
        total++; if (rf[3] !== 32'd42) begin bad++; $display("FAIL r_sub_result: got %0d want 42", rf[3]); end
    endtask

    task automatic test_random_programs();
        int n, sel, r1, r2, rb, reg_bad, mem_bad, ret_bad;
        logic [31:0] w;
        for (int t = 0; t < 8; t++) begin
            clear_image();
            for (int i = 128; i < 256; i++) img[i] = 8'($urandom);
            for (int r = 1; r < 8; r++) rf_init[r] = $urandom;
            n = $urandom_range(8, 20);
            for (int k = 0; k < n; k++) begin
                r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); rb = $urandom_range(0, 7);
                sel = $urandom_range(0, 7);
                case (sel)
                    0, 1: w = enc_i(19, r1, 0, r2, $urandom_range(0, 4095));
                    2:    w = enc_i(3, r1, 2, 0, 128 + 4 * $urandom_range(0, 31));
                    3:    w = enc_s(r1, 0, 128 + 4 * $urandom_range(0, 31));
                    4:    w = enc_r(0, r2, rb, 0, r1);
                    5:    w = enc_r(1, r2, rb, 0, r1);
                    6:    w = enc_r(0, r2, rb, 6 + $urandom_range(0, 1), r1);
                    default: w = enc_b(rb, $urandom_range(0, 1) ? rb : r2, 4 * $urandom_range(1, 2));
                endcase
                put_word(4 * k, w);
            end
            model_run();
            run_prog(exp_halt + 20);
            total++; if (halt_cyc !== exp_halt) begin
                bad++; $display("FAIL rand%0d_halt: got %0d want %0d", t, halt_cyc, exp_halt);
            end
            ret_bad = (ret_q.size() != exp_ret.size()) ? 1 : 0;
            for (int i = 0; i < ret_q.size() && i < exp_ret.size(); i++) if (ret_q[i] != exp_ret[i]) ret_bad++;
            total++; if (ret_bad != 0) begin
                bad++; $display("FAIL rand%0d_retire: got %0d pulses (%0d off) want %0d", t, ret_q.size(), ret_bad, exp_ret.size());
            end
            reg_bad = 0;
            for (int r = 0; r < 8; r++) if (rf[r] !== m_rf[r]) reg_bad++;
            total++; if (reg_bad != 0) begin bad++; $display("FAIL rand%0d_regs: got %0d wrong regs want 0", t, reg_bad); end
            mem_bad = 0;
            for (int i = 128; i < 256; i++) if (mem[i] !== m_mem[i]) mem_bad++;
            total++; if (mem_bad != 0) begin bad++; $display("FAIL rand%0d_mem: got %0d wrong bytes want 0", t, mem_bad); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        for (int i = 0; i < 32; i++) rf_init[i] = 32'd0;
        test_reset();
        test_standard_program();
        test_branch(1'b0);
        test_branch(1'b1);
        test_sw();
        test_illegal();
        test_reset_mid();
        test_rtype_funct();
        test_random_programs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
